// File: rtl/s_axi4l_wr_pipe.sv
// Pipelined AXI4-Lite write slave: AW/W FIFOs feed an in-order issue stage that drives a
// valid/ready register-write port, and responses queue in a B FIFO. Option macro: AXI4L_WR_PROT_CHECK_EN.
module s_axi4l_wr_pipe #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 4,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int AW_DEPTH       = 2,
    parameter int W_DEPTH        = 2,
    parameter int B_DEPTH        = 2,
    parameter int NUM_REGS       = 4
) (
    input  logic                      i_axi_clock,
    input  logic                      i_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] i_axi_awaddr,
    input  logic [2:0]                i_axi_awprot,
    input  logic                      i_axi_awaddr_valid,
    output logic                      o_axi_awaddr_ready,
    input  logic [AXI_DATA_WIDTH-1:0] i_axi_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] i_axi_wstrb,
    input  logic                      i_axi_wdata_valid,
    output logic                      o_axi_wdata_ready,
    output logic [1:0]                o_axi_bresp,
    output logic                      o_axi_bvalid,
    input  logic                      i_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0] o_waddr,
    output logic [AXI_DATA_WIDTH-1:0] o_wdata,
    output logic [AXI_STRB_WIDTH-1:0] o_wstrb,
    output logic                      o_wvalid,
    input  logic                      i_wready
);

    localparam int AW_PW      = $clog2(AW_DEPTH);
    localparam int W_PW       = $clog2(W_DEPTH);
    localparam int B_PW       = $clog2(B_DEPTH);
    localparam int CW         = B_PW + 1;
    localparam int STRB_SHIFT = $clog2(AXI_STRB_WIDTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t state_q, state_d;

    logic readyEn_q;

    logic [AXI_ADDR_WIDTH-1:0] awAddrMem [AW_DEPTH];
    logic [AW_PW:0]            awWrPtr_q, awWrPtr_d, awRdPtr_q, awRdPtr_d;
    logic                      awFull, awEmpty, awPush, awPop;
    logic [AXI_ADDR_WIDTH-1:0] awHeadAddr;

    logic [AXI_DATA_WIDTH-1:0] wDataMem [W_DEPTH];
    logic [AXI_STRB_WIDTH-1:0] wStrbMem [W_DEPTH];
    logic [W_PW:0]             wWrPtr_q, wWrPtr_d, wRdPtr_q, wRdPtr_d;
    logic                      wFull, wEmpty, wPush, wPop;

    logic [1:0]                bRespMem [B_DEPTH];
    logic [B_PW:0]             bWrPtr_q, bWrPtr_d, bRdPtr_q, bRdPtr_d;
    logic                      bEmpty, bPush, bPop;
    logic [1:0]                bPushResp;

    logic [CW-1:0]             credit_q, credit_d;
    logic                      creditOk, issue, rangeOk, accessOk;
    logic [31:0]               awWordIdx;

    logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AXI_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                      wvalid_q, wvalid_d;

    // Ready is held low until the first clock after reset so every output reads 0 in reset.
    assign awFull  = (awWrPtr_q[AW_PW] != awRdPtr_q[AW_PW]) &&
                     (awWrPtr_q[AW_PW-1:0] == awRdPtr_q[AW_PW-1:0]);
    assign awEmpty = (awWrPtr_q == awRdPtr_q);
    assign o_axi_awaddr_ready = readyEn_q && !awFull;
    assign awPush    = i_axi_awaddr_valid && o_axi_awaddr_ready;
    assign awWrPtr_d = awWrPtr_q + (AW_PW + 1)'(awPush);
    assign awRdPtr_d = awRdPtr_q + (AW_PW + 1)'(awPop);
    assign awHeadAddr = awAddrMem[awRdPtr_q[AW_PW-1:0]];

    assign wFull  = (wWrPtr_q[W_PW] != wRdPtr_q[W_PW]) &&
                    (wWrPtr_q[W_PW-1:0] == wRdPtr_q[W_PW-1:0]);
    assign wEmpty = (wWrPtr_q == wRdPtr_q);
    assign o_axi_wdata_ready = readyEn_q && !wFull;
    assign wPush    = i_axi_wdata_valid && o_axi_wdata_ready;
    assign wWrPtr_d = wWrPtr_q + (W_PW + 1)'(wPush);
    assign wRdPtr_d = wRdPtr_q + (W_PW + 1)'(wPop);

    assign bEmpty       = (bWrPtr_q == bRdPtr_q);
    assign o_axi_bvalid = !bEmpty;
    assign o_axi_bresp  = bEmpty ? RESP_OKAY : bRespMem[bRdPtr_q[B_PW-1:0]];
    assign bPop         = o_axi_bvalid && i_axi_bready;
    assign bWrPtr_d     = bWrPtr_q + (B_PW + 1)'(bPush);
    assign bRdPtr_d     = bRdPtr_q + (B_PW + 1)'(bPop);

    // Credits count queued responses plus the write currently on the register port,
    // so the B FIFO can never overflow and needs no full flag.
    assign creditOk = (credit_q < CW'(B_DEPTH));
    assign credit_d = credit_q + CW'(issue) - CW'(bPop);

    assign awWordIdx = 32'(awHeadAddr >> STRB_SHIFT);
    assign rangeOk   = (awWordIdx < 32'(NUM_REGS));

`ifdef AXI4L_WR_PROT_CHECK_EN
    logic [2:0] awProtMem [AW_DEPTH];
    logic [2:0] awHeadProt;

    assign awHeadProt = awProtMem[awRdPtr_q[AW_PW-1:0]];
    assign accessOk   = rangeOk && awHeadProt[0];

    always_ff @(posedge i_axi_clock) begin
        if (awPush) begin
            awProtMem[awWrPtr_q[AW_PW-1:0]] <= i_axi_awprot;
        end
    end
`else
    logic unusedProt;

    assign unusedProt = ^i_axi_awprot;
    assign accessOk   = rangeOk;
`endif

    assign o_waddr  = waddr_q;
    assign o_wdata  = wdata_q;
    assign o_wstrb  = wstrb_q;
    assign o_wvalid = wvalid_q;

    // FIFO storage carries no reset; emptiness is defined entirely by the pointers.
    always_ff @(posedge i_axi_clock) begin
        if (awPush) begin
            awAddrMem[awWrPtr_q[AW_PW-1:0]] <= i_axi_awaddr;
        end
        if (wPush) begin
            wDataMem[wWrPtr_q[W_PW-1:0]] <= i_axi_wdata;
            wStrbMem[wWrPtr_q[W_PW-1:0]] <= i_axi_wstrb;
        end
        if (bPush) begin
            bRespMem[bWrPtr_q[B_PW-1:0]] <= bPushResp;
        end
    end

    // Rejected writes retire straight from IDLE; accepted ones hold the port until i_wready.
    always_comb begin
        state_d   = state_q;
        awPop     = 1'b0;
        wPop      = 1'b0;
        bPush     = 1'b0;
        bPushResp = RESP_OKAY;
        issue     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wvalid_d  = wvalid_q;

        case (state_q)
            IDLE: begin
                if (!awEmpty && !wEmpty && creditOk) begin
                    issue = 1'b1;
                    if (accessOk) begin
                        waddr_d  = awHeadAddr;
                        wdata_d  = wDataMem[wRdPtr_q[W_PW-1:0]];
                        wstrb_d  = wStrbMem[wRdPtr_q[W_PW-1:0]];
                        wvalid_d = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        awPop     = 1'b1;
                        wPop      = 1'b1;
                        bPush     = 1'b1;
                        bPushResp = RESP_SLVERR;
                    end
                end
            end
            ISSUE: begin
                if (i_wready) begin
                    awPop     = 1'b1;
                    wPop      = 1'b1;
                    bPush     = 1'b1;
                    bPushResp = RESP_OKAY;
                    wvalid_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                wvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            state_q   <= IDLE;
            readyEn_q <= 1'b0;
            awWrPtr_q <= '0;
            awRdPtr_q <= '0;
            wWrPtr_q  <= '0;
            wRdPtr_q  <= '0;
            bWrPtr_q  <= '0;
            bRdPtr_q  <= '0;
            credit_q  <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            readyEn_q <= 1'b1;
            awWrPtr_q <= awWrPtr_d;
            awRdPtr_q <= awRdPtr_d;
            wWrPtr_q  <= wWrPtr_d;
            wRdPtr_q  <= wRdPtr_d;
            bWrPtr_q  <= bWrPtr_d;
            bRdPtr_q  <= bRdPtr_d;
            credit_q  <= credit_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wvalid_q  <= wvalid_d;
        end
    end

endmodule

// File: tb/tb_s_axi4l_wr_pipe.sv
// Directed self-checking bench for s_axi4l_wr_pipe (5-bit address so out-of-range words exist).
// With AXI4L_WR_PROT_CHECK_EN defined, test_prot checks unprivileged rejection instead of prot being ignored.
`timescale 1ns/1ps
module tb_s_axi4l_wr_pipe;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clock = 1'b0;
    logic          aresetn = 1'b1;
    logic [AW-1:0] awAddr = '0;
    logic [2:0]    awProt = 3'b001;
    logic          awValid = 1'b0;
    logic          awReady;
    logic [DW-1:0] wData = '0;
    logic [SW-1:0] wStrb = '0;
    logic          wValid = 1'b0;
    logic          wReady;
    logic [1:0]    bResp;
    logic          bValid;
    logic          bReady = 1'b0;
    logic [AW-1:0] regWaddr;
    logic [DW-1:0] regWdata;
    logic [SW-1:0] regWstrb;
    logic          regWvalid;
    logic          regWready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [AW-1:0] regAddrQ[$];
    logic [DW-1:0] regDataQ[$];
    logic [1:0]    respQ[$];

    always #5 clock = ~clock;

    s_axi4l_wr_pipe #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .AW_DEPTH(2),
        .W_DEPTH(2),
        .B_DEPTH(2),
        .NUM_REGS(4)
    ) dut (
        .i_axi_clock(clock),
        .i_axi_aresetn(aresetn),
        .i_axi_awaddr(awAddr),
        .i_axi_awprot(awProt),
        .i_axi_awaddr_valid(awValid),
        .o_axi_awaddr_ready(awReady),
        .i_axi_wdata(wData),
        .i_axi_wstrb(wStrb),
        .i_axi_wdata_valid(wValid),
        .o_axi_wdata_ready(wReady),
        .o_axi_bresp(bResp),
        .o_axi_bvalid(bValid),
        .i_axi_bready(bReady),
        .o_waddr(regWaddr),
        .o_wdata(regWdata),
        .o_wstrb(regWstrb),
        .o_wvalid(regWvalid),
        .i_wready(regWready)
    );

    // Records every completed register write and B handshake, sampled mid-cycle.
    always @(negedge clock) begin
        if (aresetn && regWvalid && regWready) begin
            regAddrQ.push_back(regWaddr);
            regDataQ.push_back(regWdata);
        end
        if (aresetn && bValid && bReady) begin
            respQ.push_back(bResp);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clearQueues();
        regAddrQ.delete();
        regDataQ.delete();
        respQ.delete();
    endtask

    // Offers AW and/or W and retires each independently once its handshake edge has passed.
    task automatic sendWrite(input logic doAw, input logic doW, input logic [AW-1:0] addr,
                             input logic [2:0] prot, input logic [DW-1:0] data,
                             input logic [SW-1:0] strb);
        int n;
        logic awTake, wTake;
        n = 0;
        awAddr = addr;
        awProt = prot;
        awValid = doAw;
        wData = data;
        wStrb = strb;
        wValid = doW;
        while ((awValid || wValid) && n < 64) begin
            awTake = awValid && awReady;
            wTake = wValid && wReady;
            step();
            if (awTake) awValid = 1'b0;
            if (wTake) wValid = 1'b0;
            n++;
        end
        if (awValid || wValid) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_timeout: got awvalid=%0b wvalid=%0b pending, expected both accepted", awValid, wValid);
            awValid = 1'b0;
            wValid = 1'b0;
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        #2 aresetn = 1'b0;
        #1;
        checks++; if (awReady !== 1'b0) begin failures++; $display("[TB] FAIL rst_awready: got %0b, expected 0", awReady); end
        checks++; if (wReady !== 1'b0) begin failures++; $display("[TB] FAIL rst_wready: got %0b, expected 0", wReady); end
        checks++; if (bValid !== 1'b0) begin failures++; $display("[TB] FAIL rst_bvalid: got %0b, expected 0", bValid); end
        checks++; if (bResp !== 2'b00) begin failures++; $display("[TB] FAIL rst_bresp: got %0b, expected 00", bResp); end
        checks++; if (regWvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_wvalid: got %0b, expected 0", regWvalid); end
        checks++; if (regWaddr !== '0) begin failures++; $display("[TB] FAIL rst_waddr: got %0h, expected 0", regWaddr); end
        checks++; if (regWdata !== '0) begin failures++; $display("[TB] FAIL rst_wdata: got %0h, expected 0", regWdata); end
        checks++; if (regWstrb !== '0) begin failures++; $display("[TB] FAIL rst_wstrb: got %0h, expected 0", regWstrb); end
        step();
        step();
        aresetn = 1'b1;
        step();
        step();
        checks++; if (awReady !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_awready: got %0b, expected 1", awReady); end
        checks++; if (wReady !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_wready: got %0b, expected 1", wReady); end
    endtask

    task automatic test_single_write();
        int n;
        $display("[TB] test_single_write");
        bReady = 1'b1;
        regWready = 1'b1;
        clearQueues();
        sendWrite(1'b1, 1'b1, 5'h04, 3'b001, 32'hDEADBEEF, 4'hF);
        n = 0;
        while (!regWvalid && n < 4) begin step(); n++; end
        checks++; if (regWvalid !== 1'b1) begin failures++; $display("[TB] FAIL single_wvalid: got %0b, expected 1", regWvalid); end
        checks++; if (regWaddr !== 5'h04) begin failures++; $display("[TB] FAIL single_waddr: got %0h, expected 4", regWaddr); end
        checks++; if (regWdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_wdata: got %0h, expected deadbeef", regWdata); end
        checks++; if (regWstrb !== 4'hF) begin failures++; $display("[TB] FAIL single_wstrb: got %0h, expected f", regWstrb); end
        step();
        checks++; if (bValid !== 1'b1) begin failures++; $display("[TB] FAIL single_bvalid: got %0b, expected 1", bValid); end
        checks++; if (bResp !== 2'b00) begin failures++; $display("[TB] FAIL single_bresp: got %0b, expected 00", bResp); end
        checks++; if (regWvalid !== 1'b0) begin failures++; $display("[TB] FAIL single_wvalid_drop: got %0b, expected 0", regWvalid); end
        step();
        checks++; if (bValid !== 1'b0) begin failures++; $display("[TB] FAIL single_bpop: got %0b, expected 0", bValid); end
    endtask

    task automatic test_skewed();
        int n;
        logic stray;
        $display("[TB] test_skewed");
        sendWrite(1'b0, 1'b1, 5'h00, 3'b001, 32'h11223344, 4'h3);
        stray = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (regWvalid !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin failures++; $display("[TB] FAIL skew_early_wvalid: got %0b, expected 0", stray); end
        sendWrite(1'b1, 1'b0, 5'h08, 3'b001, 32'h0, 4'h0);
        n = 0;
        while (!regWvalid && n < 4) begin step(); n++; end
        checks++; if (regWvalid !== 1'b1) begin failures++; $display("[TB] FAIL skew_wvalid: got %0b, expected 1", regWvalid); end
        checks++; if (regWaddr !== 5'h08) begin failures++; $display("[TB] FAIL skew_waddr: got %0h, expected 8", regWaddr); end
        checks++; if (regWdata !== 32'h11223344) begin failures++; $display("[TB] FAIL skew_wdata: got %0h, expected 11223344", regWdata); end
        checks++; if (regWstrb !== 4'h3) begin failures++; $display("[TB] FAIL skew_wstrb: got %0h, expected 3", regWstrb); end
        step();
        checks++; if (bValid !== 1'b1 || bResp !== 2'b00) begin failures++; $display("[TB] FAIL skew_bresp: got valid=%0b resp=%0b, expected valid=1 resp=00", bValid, bResp); end
        step();
    endtask

    task automatic test_backpressure();
        int n;
        $display("[TB] test_backpressure");
        regWready = 1'b0;
        bReady = 1'b1;
        sendWrite(1'b1, 1'b1, 5'h0C, 3'b001, 32'hA5A5A5A5, 4'hF);
        n = 0;
        while (!regWvalid && n < 4) begin step(); n++; end
        checks++; if (regWvalid !== 1'b1) begin failures++; $display("[TB] FAIL bp_wvalid: got %0b, expected 1", regWvalid); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (regWvalid !== 1'b1 || regWaddr !== 5'h0C || regWdata !== 32'hA5A5A5A5 || regWstrb !== 4'hF) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d: got v=%0b a=%0h d=%0h s=%0h, expected v=1 a=c d=a5a5a5a5 s=f", i, regWvalid, regWaddr, regWdata, regWstrb);
            end
        end
        regWready = 1'b1;
        step();
        checks++; if (bValid !== 1'b1 || bResp !== 2'b00) begin failures++; $display("[TB] FAIL bp_release_b: got valid=%0b resp=%0b, expected valid=1 resp=00", bValid, bResp); end
        step();

        clearQueues();
        bReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sendWrite(1'b1, 1'b1, 5'(i * 4), 3'b001, 32'hB0000000 + 32'(i), 4'hF);
        end
        for (int i = 0; i < 5; i++) step();
        checks++; if (awReady !== 1'b0) begin failures++; $display("[TB] FAIL bp_awready_full: got %0b, expected 0", awReady); end
        checks++; if (wReady !== 1'b0) begin failures++; $display("[TB] FAIL bp_wready_full: got %0b, expected 0", wReady); end
        checks++; if (bValid !== 1'b1 || bResp !== 2'b00) begin failures++; $display("[TB] FAIL bp_bstall: got valid=%0b resp=%0b, expected valid=1 resp=00", bValid, bResp); end
        checks++; if (regWvalid !== 1'b0) begin failures++; $display("[TB] FAIL bp_credit_block: got %0b, expected 0", regWvalid); end
        checks++; if (regAddrQ.size() !== 2) begin failures++; $display("[TB] FAIL bp_outstanding: got %0d, expected 2", regAddrQ.size()); end
        bReady = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checks++; if (respQ.size() !== 4) begin failures++; $display("[TB] FAIL bp_resp_count: got %0d, expected 4", respQ.size()); end
        checks++; if (regAddrQ.size() !== 4) begin failures++; $display("[TB] FAIL bp_write_count: got %0d, expected 4", regAddrQ.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < respQ.size()) begin
                checks++; if (respQ[i] !== 2'b00) begin failures++; $display("[TB] FAIL bp_resp%0d: got %0b, expected 00", i, respQ[i]); end
            end
            if (i < regAddrQ.size()) begin
                checks++; if (regAddrQ[i] !== 5'(i * 4)) begin failures++; $display("[TB] FAIL bp_addr%0d: got %0h, expected %0h", i, regAddrQ[i], i * 4); end
                checks++; if (regDataQ[i] !== 32'hB0000000 + 32'(i)) begin failures++; $display("[TB] FAIL bp_data%0d: got %0h, expected %0h", i, regDataQ[i], 32'hB0000000 + 32'(i)); end
            end
        end
    endtask

    task automatic test_error();
        $display("[TB] test_error");
        bReady = 1'b1;
        regWready = 1'b1;
        clearQueues();
        sendWrite(1'b1, 1'b1, 5'h0C, 3'b001, 32'h00000111, 4'hF);
        sendWrite(1'b1, 1'b1, 5'h10, 3'b001, 32'h00000222, 4'hF);
        sendWrite(1'b1, 1'b1, 5'h08, 3'b001, 32'h00000333, 4'hF);
        for (int i = 0; i < 12; i++) step();
        checks++; if (regAddrQ.size() !== 2) begin failures++; $display("[TB] FAIL err_write_count: got %0d, expected 2", regAddrQ.size()); end
        if (regAddrQ.size() == 2) begin
            checks++; if (regAddrQ[0] !== 5'h0C || regDataQ[0] !== 32'h111) begin failures++; $display("[TB] FAIL err_write0: got %0h/%0h, expected c/111", regAddrQ[0], regDataQ[0]); end
            checks++; if (regAddrQ[1] !== 5'h08 || regDataQ[1] !== 32'h333) begin failures++; $display("[TB] FAIL err_write1: got %0h/%0h, expected 8/333", regAddrQ[1], regDataQ[1]); end
        end
        checks++; if (respQ.size() !== 3) begin failures++; $display("[TB] FAIL err_resp_count: got %0d, expected 3", respQ.size()); end
        if (respQ.size() == 3) begin
            checks++; if (respQ[0] !== 2'b00) begin failures++; $display("[TB] FAIL err_resp0: got %0b, expected 00", respQ[0]); end
            checks++; if (respQ[1] !== 2'b10) begin failures++; $display("[TB] FAIL err_resp1: got %0b, expected 10", respQ[1]); end
            checks++; if (respQ[2] !== 2'b00) begin failures++; $display("[TB] FAIL err_resp2: got %0b, expected 00", respQ[2]); end
        end
    endtask

    task automatic test_reset_inflight();
        $display("[TB] test_reset_inflight");
        regWready = 1'b0;
        bReady = 1'b0;
        clearQueues();
        sendWrite(1'b1, 1'b1, 5'h00, 3'b001, 32'hAAAA0000, 4'hF);
        sendWrite(1'b1, 1'b1, 5'h04, 3'b001, 32'hAAAA0004, 4'hF);
        checks++; if (regWvalid !== 1'b1) begin failures++; $display("[TB] FAIL rif_in_issue: got %0b, expected 1", regWvalid); end
        aresetn = 1'b0;
        #1;
        checks++;
        if (regWvalid !== 1'b0 || regWaddr !== '0 || regWdata !== '0 || regWstrb !== '0) begin
            failures++;
            $display("[TB] FAIL rif_port_zero: got v=%0b a=%0h d=%0h s=%0h, expected all 0", regWvalid, regWaddr, regWdata, regWstrb);
        end
        checks++;
        if (bValid !== 1'b0 || bResp !== 2'b00 || awReady !== 1'b0 || wReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rif_axi_zero: got bv=%0b br=%0b awr=%0b wr=%0b, expected all 0", bValid, bResp, awReady, wReady);
        end
        step();
        step();
        aresetn = 1'b1;
        regWready = 1'b1;
        bReady = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++; if (regAddrQ.size() !== 0) begin failures++; $display("[TB] FAIL rif_stale_write: got %0d, expected 0", regAddrQ.size()); end
        checks++; if (respQ.size() !== 0) begin failures++; $display("[TB] FAIL rif_stale_resp: got %0d, expected 0", respQ.size()); end
        sendWrite(1'b1, 1'b1, 5'h04, 3'b001, 32'hCAFEF00D, 4'h1);
        for (int i = 0; i < 8; i++) step();
        checks++; if (regAddrQ.size() !== 1) begin failures++; $display("[TB] FAIL rif_resume_count: got %0d, expected 1", regAddrQ.size()); end
        if (regAddrQ.size() == 1) begin
            checks++; if (regAddrQ[0] !== 5'h04 || regDataQ[0] !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL rif_resume_write: got %0h/%0h, expected 4/cafef00d", regAddrQ[0], regDataQ[0]); end
        end
        checks++; if (respQ.size() !== 1) begin failures++; $display("[TB] FAIL rif_resume_resp: got %0d, expected 1", respQ.size()); end
    endtask

`ifdef AXI4L_WR_PROT_CHECK_EN
    task automatic test_prot();
        $display("[TB] test_prot (check enabled)");
        bReady = 1'b1;
        regWready = 1'b1;
        clearQueues();
        sendWrite(1'b1, 1'b1, 5'h00, 3'b000, 32'h0BAD0BAD, 4'hF);
        for (int i = 0; i < 8; i++) step();
        checks++; if (regAddrQ.size() !== 0) begin failures++; $display("[TB] FAIL prot_unpriv_write: got %0d, expected 0", regAddrQ.size()); end
        checks++; if (respQ.size() !== 1 || respQ[0] !== 2'b10) begin failures++; $display("[TB] FAIL prot_unpriv_resp: got n=%0d, expected one SLVERR", respQ.size()); end
        clearQueues();
        sendWrite(1'b1, 1'b1, 5'h00, 3'b001, 32'h600D600D, 4'hF);
        for (int i = 0; i < 8; i++) step();
        checks++; if (regAddrQ.size() !== 1 || regDataQ[0] !== 32'h600D600D) begin failures++; $display("[TB] FAIL prot_priv_write: got n=%0d, expected one write of 600d600d", regAddrQ.size()); end
        checks++; if (respQ.size() !== 1 || respQ[0] !== 2'b00) begin failures++; $display("[TB] FAIL prot_priv_resp: got n=%0d, expected one OKAY", respQ.size()); end
    endtask
`else
    task automatic test_prot();
        $display("[TB] test_prot (prot ignored)");
        bReady = 1'b1;
        regWready = 1'b1;
        clearQueues();
        sendWrite(1'b1, 1'b1, 5'h00, 3'b000, 32'h0000ABCD, 4'h0);
        for (int i = 0; i < 8; i++) step();
        checks++; if (regAddrQ.size() !== 1 || regDataQ[0] !== 32'h0000ABCD) begin failures++; $display("[TB] FAIL prot_ignored_write: got n=%0d, expected one write of abcd", regAddrQ.size()); end
        checks++; if (respQ.size() !== 1 || respQ[0] !== 2'b00) begin failures++; $display("[TB] FAIL prot_ignored_resp: got n=%0d, expected one OKAY", respQ.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_skewed();
        test_backpressure();
        test_error();
        test_reset_inflight();
        test_prot();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        failures++;
        $display("[TB] FAIL watchdog: got no completion by 200us, expected all tests done");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
